pe_array_controller: RTL
========================

// Module: pe_array_controller
// PURPOSE
//  Sequences a 1-D chain of NUM_PE ternary-weight processing elements: loads one 2-bit weight
//  per PE, streams cfg_num_vec input vectors through the chain, then drains the pipeline.
//  Generates each PE's enable/weight_read strobes and an out_valid for the chain's data_out.
//  Sits between the weight/activation buffers and the PE chain; started by the top-level sequencer.
// PARAMETERS
//  NUM_PE      4              number of PEs in the chain (>=2)
//  PIPE_DEPTH  NUM_PE         enabled cycles from input accept to valid data_out at chain end
//  CNT_W       16             width of vector counter and cfg_num_vec
//  ROW_W       $clog2(NUM_PE) width of w_row
// PORTS
//  clock           in   1          single clock, all state on rising edge
//  reset_n         in   1          asynchronous, active-low reset
//  start           in   1          begin a job; sampled only in IDLE, ignored otherwise
//  abort           in   1          synchronous abort; any state -> IDLE next cycle
//  cfg_num_vec     in   CNT_W      vectors per job; latched when start is accepted
//  w_valid         in   1          weight beat available
//  w_ready         out  1          controller accepts a weight beat (LOAD_W only)
//  w_row           out  ROW_W      index of PE receiving the current weight beat
//  pe_weight_read  out  NUM_PE     one-hot weight-latch strobe = (w_valid & w_ready) << w_row
//  in_valid        in   1          activation vector available
//  in_ready        out  1          controller accepts a vector (STREAM only)
//  pe_enable       out  1          advance all PEs this cycle
//  out_valid       out  1          chain data_out valid this cycle
//  busy            out  1          high in every state except IDLE
//  done            out  1          one-cycle pulse at job completion
// BEHAVIOUR
//  Reset: state=IDLE; w_row, vec_cnt, drain_cnt, vld_sr = 0. All outputs 0.
//  FSM states: IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches cfg_num_vec and enters LOAD_W the next cycle.
//  LOAD_W:
//   - w_ready=1. On each accept, pe_weight_read is the combinational one-hot of w_row in the same cycle.
//   - w_row increments on each accept. The accept at w_row=NUM_PE-1 wraps w_row to 0.
//   - Next state after that accept: STREAM, or DONE if the latched count is 0.
//   - pe_enable=0 throughout LOAD_W.
//  STREAM:
//   - in_ready=1 and pe_enable=in_valid; no valid means a stall and no advance.
//   - vec_cnt increments per accept. The accept with vec_cnt==count-1 clears vec_cnt and goes to DRAIN.
//  DRAIN:
//   - in_ready=0, pe_enable=1 for exactly PIPE_DEPTH cycles (drain_cnt), then DONE.
//  DONE: done=1 and busy=1 for one cycle, then IDLE.
//  A start in the DONE cycle is ignored.
//  Valid tracking:
//   - vld_sr is a PIPE_DEPTH-bit register that shifts only when pe_enable=1:
//     vld_sr <= {vld_sr[PIPE_DEPTH-2:0], in_valid&in_ready}.
//   - out_valid = vld_sr[PIPE_DEPTH-1] & pe_enable. It is 0 on stall cycles, when the PE output is held.
//   - Exactly count out_valid cycles per job. The last one occurs in the final DRAIN cycle.
//  abort (priority over all but reset):
//   - Forces IDLE and clears counters and vld_sr next cycle. No done pulse.
//   - Combinational strobes deassert in the abort cycle.
//  Reset mid-job returns all state to reset values immediately (async).
//  Widths: vec_cnt/cfg are unsigned CNT_W, with no wrap since the compare is ==count-1.
//  drain_cnt is $clog2(PIPE_DEPTH+1) bits.
// STRUCTURE
//  pe_ctrl_pkg:
//   - typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} pe_ctrl_state_t.
//   - weight encoding constants W_NEG=-1, W_ZERO=0, W_POS=1.
//  Sub-module pe_valid_pipe: the enable-gated vld_sr shift register with param DEPTH.
//  Everything else (FSM, counters, strobe decode) stays in pe_array_controller.
// TESTING
//  1 reset (NUM_PE=4): reset_n low mid-clock -> all outputs 0 immediately.
//    After release: busy=0, w_ready=0, in_ready=0.
//  2 start, cfg=3, weights {-1,0,1,1} with w_valid=1 -> pe_weight_read=0001,0010,0100,1000 on 4
//    consecutive cycles, then w_ready=0 and in_ready=1.
//  3 3 vectors, in_valid held 1 -> pe_enable high 3+4 cycles; out_valid high on cycles 5,6,7 of
//    enable; done pulses the cycle after; busy falls with it.
//  4 same job with in_valid=1,0,0,1,0,1 -> pe_enable tracks in_valid, out_valid never on stall
//    cycles, total out_valid count=3, DRAIN length still 4.
//  5 cfg=0 -> after 4 weight beats go to DONE; pe_enable never asserted, out_valid count 0.
//  6 abort on 2nd STREAM accept -> IDLE next cycle, no done, vld_sr cleared.
//    A new start then runs the job in scenario 3 exactly; a start while busy has no effect.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE-array controller slice.
package pe_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } pe_ctrl_state_t;

  // Two-bit two's-complement ternary weight encoding as latched by each PE.
  typedef logic [1:0] pe_weight_t;

  localparam pe_weight_t W_NEG  = 2'b11;  // -1
  localparam pe_weight_t W_ZERO = 2'b00;  //  0
  localparam pe_weight_t W_POS  = 2'b01;  // +1

endpackage

// File: rtl/pe_valid_pipe.sv
// Enable-gated valid shift register that mirrors the data occupancy of the PE chain.
module pe_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,    // chain advances this cycle
  input  logic clear,     // drop all in-flight valids
  input  logic din,       // a vector enters the chain this cycle
  output logic dout       // the vector at the chain end is valid
);

  logic [DEPTH-1:0] vld_sr;

  // Shift one position per enabled cycle; hold on stalls so valids stay aligned with data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr <= '0;
    end else if (clear) begin
      vld_sr <= '0;
    end else if (enable) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      vld_sr <= {vld_sr[DEPTH-2:0], din};
    end
  end

  assign dout = vld_sr[DEPTH-1];

endmodule

// File: rtl/pe_array_controller.sv
// Sequences weight load, vector streaming and pipeline drain for a 1-D ternary PE chain.
module pe_array_controller
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int PIPE_DEPTH = NUM_PE,
  parameter int CNT_W      = 16,
  parameter int ROW_W      = $clog2(NUM_PE)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_num_vec,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [ROW_W-1:0]  w_row,
  output logic [NUM_PE-1:0] pe_weight_read,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pe_enable,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int DRN_W = $clog2(PIPE_DEPTH + 1);

  pe_ctrl_state_t   state;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] vec_cnt;
  logic [ROW_W-1:0] w_row_q;
  logic [DRN_W-1:0] drain_cnt;

  logic w_accept;
  logic v_accept;
  logic last_row;
  logic last_vec;
  logic last_drain;
  logic chain_tail_vld;

  // Handshakes are suppressed during abort so no beat is consumed in the cycle being discarded.
  assign w_ready   = (state == LOAD_W) && !abort;
  assign in_ready  = (state == STREAM) && !abort;
  assign w_accept  = w_valid && w_ready;
  assign v_accept  = in_valid && in_ready;

  // The chain advances on every accepted vector and on every drain cycle.
  assign pe_enable      = v_accept || ((state == DRAIN) && !abort);
  assign pe_weight_read = w_accept ? (NUM_PE'(1) << w_row_q) : '0;
  assign out_valid      = chain_tail_vld && pe_enable;

  assign w_row = w_row_q;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  assign last_row   = (w_row_q == ROW_W'(NUM_PE - 1));
  assign last_vec   = (vec_cnt == num_vec_q - CNT_W'(1));
  assign last_drain = (drain_cnt == DRN_W'(PIPE_DEPTH - 1));

  // Job sequencer: state, latched job length and all progress counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      num_vec_q <= '0;
      vec_cnt   <= '0;
      w_row_q   <= '0;
      drain_cnt <= '0;
    end else if (abort) begin
      state     <= IDLE;
      num_vec_q <= '0;
      vec_cnt   <= '0;
      w_row_q   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_vec_q <= cfg_num_vec;
            state     <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_accept) begin
            if (last_row) begin
              w_row_q <= '0;
              state   <= (num_vec_q == '0) ? DONE : STREAM;
            end else begin
              w_row_q <= w_row_q + ROW_W'(1);
            end
          end
        end
        STREAM: begin
          if (v_accept) begin
            if (last_vec) begin
              vec_cnt <= '0;
              state   <= DRAIN;
            end else begin
              vec_cnt <= vec_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (last_drain) begin
            drain_cnt <= '0;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt + DRN_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Valid occupancy of the PE chain, flushed on abort.
  pe_valid_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_valid_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (pe_enable),
    .clear   (abort),
    .din     (v_accept),
    .dout    (chain_tail_vld)
  );

endmodule
